// File: rtl/datapath_regfile.sv
// Register file and shared-bus datapath below the processor control unit.
// Holds PC/AR/IR/AC/R/R1-R4 and a four-op ALU that writes AC.
module datapath_regfile #(
  parameter int DW     = 16,
  parameter int RSEL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RSEL_W-1:0] read_en,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic [2:0]        alu_op,
  input  logic [DW-1:0]     im_rdata,
  input  logic [DW-1:0]     dm_rdata,
  output logic [DW-1:0]     im_addr,
  output logic [DW-1:0]     dm_addr,
  output logic [DW-1:0]     dm_wdata,
  output logic              dm_we,
  output logic [DW-1:0]     instruction,
  output logic [DW-1:0]     z,
  output logic [DW-1:0]     bus_dbg
);

  localparam int B_PC = 1;
  localparam int B_AR = 2;
  localparam int B_IR = 3;
  localparam int B_AC = 4;
  localparam int B_R  = 5;
  localparam int B_R4 = 6;
  localparam int B_R3 = 7;
  localparam int B_R2 = 8;
  localparam int B_R1 = 9;
  localparam int B_DM = 11;

  localparam logic [RSEL_W-1:0] SEL_PC = RSEL_W'(1);
  localparam logic [RSEL_W-1:0] SEL_AR = RSEL_W'(2);
  localparam logic [RSEL_W-1:0] SEL_IR = RSEL_W'(4);
  localparam logic [RSEL_W-1:0] SEL_AC = RSEL_W'(5);
  localparam logic [RSEL_W-1:0] SEL_R  = RSEL_W'(6);
  localparam logic [RSEL_W-1:0] SEL_R1 = RSEL_W'(7);
  localparam logic [RSEL_W-1:0] SEL_R2 = RSEL_W'(8);
  localparam logic [RSEL_W-1:0] SEL_R3 = RSEL_W'(9);
  localparam logic [RSEL_W-1:0] SEL_R4 = RSEL_W'(10);
  localparam logic [RSEL_W-1:0] SEL_DM = RSEL_W'(12);
  localparam logic [RSEL_W-1:0] SEL_IM = RSEL_W'(13);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;

  logic [DW-1:0] pc_q, ar_q, ir_q, ac_q, r_q, r1_q, r2_q, r3_q, r4_q;
  logic [DW-1:0] pc_d, ar_d, ir_d, ac_d, r_d, r1_d, r2_d, r3_d, r4_d;
  logic [DW-1:0] bus;
  logic [DW-1:0] alu_res;
  logic          alu_wr;
  logic          unused_en;

  // Enable bits with no register behind them; DM only uses its load bit.
  assign unused_en = ^{write_en[0], write_en[10], write_en[15:12],
                       inc_en[0], inc_en[15:10], clr_en[0], clr_en[15:10]};

  always_comb begin
    bus = '0;
    unique case (read_en)
      SEL_PC:  bus = pc_q;
      SEL_AR:  bus = ar_q;
      SEL_IR:  bus = ir_q;
      SEL_AC:  bus = ac_q;
      SEL_R:   bus = r_q;
      SEL_R1:  bus = r1_q;
      SEL_R2:  bus = r2_q;
      SEL_R3:  bus = r3_q;
      SEL_R4:  bus = r4_q;
      SEL_DM:  bus = dm_rdata;
      SEL_IM:  bus = im_rdata;
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu_res = ac_q;
    alu_wr  = 1'b1;
    unique case (alu_op)
      OP_ADD:  alu_res = ac_q + r_q;
      OP_SUB:  alu_res = ac_q - r_q;
      OP_MUL:  alu_res = ac_q * r_q;
      OP_SHL:  alu_res = {ac_q[DW-2:0], 1'b0};
      default: alu_wr  = 1'b0;
    endcase
  end

  function automatic logic [DW-1:0] reg_next(input logic [DW-1:0] cur,
                                             input logic [DW-1:0] bus_v,
                                             input logic clr, input logic ld,
                                             input logic inc);
    logic [DW-1:0] nxt;
    nxt = cur;
    if (clr)      nxt = '0;
    else if (ld)  nxt = bus_v;
    else if (inc) nxt = cur + DW'(1);
    return nxt;
  endfunction

  always_comb begin
    pc_d = reg_next(pc_q, bus, clr_en[B_PC], write_en[B_PC], inc_en[B_PC]);
    ar_d = reg_next(ar_q, bus, clr_en[B_AR], write_en[B_AR], inc_en[B_AR]);
    ir_d = reg_next(ir_q, bus, clr_en[B_IR], write_en[B_IR], inc_en[B_IR]);
    r_d  = reg_next(r_q,  bus, clr_en[B_R],  write_en[B_R],  inc_en[B_R]);
    r1_d = reg_next(r1_q, bus, clr_en[B_R1], write_en[B_R1], inc_en[B_R1]);
    r2_d = reg_next(r2_q, bus, clr_en[B_R2], write_en[B_R2], inc_en[B_R2]);
    r3_d = reg_next(r3_q, bus, clr_en[B_R3], write_en[B_R3], inc_en[B_R3]);
    r4_d = reg_next(r4_q, bus, clr_en[B_R4], write_en[B_R4], inc_en[B_R4]);
  end

  // AC: an ALU write outranks a bus load, but a clear outranks both.
  always_comb begin
    ac_d = ac_q;
    if (clr_en[B_AC])        ac_d = '0;
    else if (alu_wr)         ac_d = alu_res;
    else if (write_en[B_AC]) ac_d = bus;
    else if (inc_en[B_AC])   ac_d = ac_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ar_q <= '0;
      ir_q <= '0;
      ac_q <= '0;
      r_q  <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      r4_q <= '0;
    end else begin
      pc_q <= pc_d;
      ar_q <= ar_d;
      ir_q <= ir_d;
      ac_q <= ac_d;
      r_q  <= r_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      r4_q <= r4_d;
    end
  end

  assign im_addr     = pc_q;
  assign dm_addr     = ar_q;
  assign dm_wdata    = bus;
  assign dm_we       = write_en[B_DM];
  assign instruction = ir_q;
  assign z           = {{(DW-1){1'b0}}, (ac_q == '0)};
  assign bus_dbg     = bus;

endmodule

// File: tb/tb_datapath_regfile.sv
// Self-checking bench for datapath_regfile: expectations queued at stimulus
// time, popped and compared once the DUT output is due.
module tb_datapath_regfile;

  logic        clk;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic [15:0] im_rdata, dm_rdata;
  logic [15:0] im_addr, dm_addr, dm_wdata, instruction, z, bus_dbg;
  logic        dm_we;

  datapath_regfile #(.DW(16), .RSEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
    .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z), .bus_dbg(bus_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_IMA, S_DMA, S_DMW, S_DWE, S_INS, S_Z, S_BUS} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input sig_e s);
    case (s)
      S_IMA:   return im_addr;
      S_DMA:   return dm_addr;
      S_DMW:   return dm_wdata;
      S_DWE:   return {15'b0, dm_we};
      S_INS:   return instruction;
      S_Z:     return z;
      default: return bus_dbg;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic idle();
    read_en  = 4'd0;
    write_en = 16'h0;
    inc_en   = 16'h0;
    clr_en   = 16'h0;
    alu_op   = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int bit_i, input logic [15:0] v);
    read_en  = 4'd13;
    im_rdata = v;
    write_en = 16'h0001 << bit_i;
    tick();
    idle();
  endtask

  task automatic peek(input logic [3:0] sel, input string tag, input logic [15:0] v);
    push(tag, S_BUS, v);
    read_en = sel;
    #1;
    drain();
    read_en = 4'd0;
  endtask

  task automatic alu(input logic [2:0] op);
    alu_op = op;
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    im_rdata = 16'h0;
    dm_rdata = 16'h0;
    #3;
    push("rst_ima", S_IMA, 16'h0000);
    push("rst_dma", S_DMA, 16'h0000);
    push("rst_ins", S_INS, 16'h0000);
    push("rst_z",   S_Z,   16'h0001);
    push("rst_bus", S_BUS, 16'h0000);
    drain();
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in mid-cycle
    load(4, 16'h1234);
    load(1, 16'h0005);
    push("pre_rst_ima", S_IMA, 16'h0005);
    push("pre_rst_z",   S_Z,   16'h0000);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_ima", S_IMA, 16'h0000);
    push("arst_z",   S_Z,   16'h0001);
    drain();
    peek(4'd5, "arst_ac", 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch then PC increment
    load(1, 16'h0003);
    read_en = 4'd13; im_rdata = 16'hABCD; write_en = 16'h0008;
    push("fetch_ir", S_INS, 16'hABCD);
    tick(); idle(); drain();
    inc_en = 16'h0002;
    push("pc_inc", S_IMA, 16'h0004);
    tick(); idle(); drain();

    // ALU
    load(5, 16'h0003);
    load(4, 16'h0005);
    push("add_z", S_Z, 16'h0000);
    alu(3'd1);
    peek(4'd5, "add_ac", 16'h0008);
    load(4, 16'h0003);
    push("sub_z", S_Z, 16'h0001);
    alu(3'd2);
    peek(4'd5, "sub_ac", 16'h0000);
    alu(3'd2);
    peek(4'd5, "sub_wrap", 16'hFFFD);
    load(4, 16'h8001);
    alu(3'd4);
    peek(4'd5, "shl_ac", 16'h0002);
    load(4, 16'h0100);
    load(5, 16'h0100);
    push("mul_z", S_Z, 16'h0001);
    alu(3'd3);
    peek(4'd5, "mul_ac", 16'h0000);
    peek(4'd6, "mul_r", 16'h0100);

    // AC priority
    load(5, 16'h0003);
    load(4, 16'h1111);
    clr_en = 16'h0010; alu_op = 3'd1; read_en = 4'd13; im_rdata = 16'h7777; write_en = 16'h0010;
    tick(); idle();
    peek(4'd5, "pri_clr", 16'h0000);
    load(4, 16'h0005);
    alu_op = 3'd1; read_en = 4'd13; im_rdata = 16'h7777; write_en = 16'h0010;
    tick(); idle();
    peek(4'd5, "pri_alu", 16'h0008);
    read_en = 4'd13; im_rdata = 16'h0042; write_en = 16'h0010; inc_en = 16'h0010;
    tick(); idle();
    peek(4'd5, "pri_ld_inc", 16'h0042);
    inc_en = 16'h0010;
    tick(); idle();
    peek(4'd5, "ac_inc", 16'h0043);
    alu_op = 3'd5; read_en = 4'd13; im_rdata = 16'h0099; write_en = 16'h0010;
    tick(); idle();
    peek(4'd5, "op5_noalu", 16'h0099);
    load(1, 16'hFFFF);
    inc_en = 16'h0002;
    push("pc_wrap", S_IMA, 16'h0000);
    tick(); idle(); drain();
    load(1, 16'h0020);
    read_en = 4'd13; im_rdata = 16'h0055; write_en = 16'h0002; clr_en = 16'h0002;
    push("pc_clr_ld", S_IMA, 16'h0000);
    tick(); idle(); drain();

    // Register moves and unused selects
    load(4, 16'h00AA);
    read_en = 4'd5; write_en = 16'h0200;
    tick(); idle();
    peek(4'd7, "mv_r1", 16'h00AA);
    clr_en = 16'h0010;
    push("ac_clr_z", S_Z, 16'h0001);
    tick(); idle(); drain();
    read_en = 4'd7; write_en = 16'h0010;
    tick(); idle();
    peek(4'd5, "mv_ac", 16'h00AA);
    peek(4'd15, "sel15", 16'h0000);
    peek(4'd3,  "sel3",  16'h0000);
    peek(4'd11, "sel11", 16'h0000);
    peek(4'd14, "sel14", 16'h0000);
    peek(4'd4,  "ir_bus", 16'hABCD);
    read_en = 4'd12; dm_rdata = 16'h2222; write_en = 16'h0100;
    tick(); idle();
    peek(4'd8, "r2_dm", 16'h2222);
    load(7, 16'h3333);
    peek(4'd9, "r3", 16'h3333);
    load(6, 16'h4444);
    peek(4'd10, "r4", 16'h4444);

    // Self-source load with multiple targets
    load(1, 16'h0007);
    read_en = 4'd1; write_en = 16'h0006; inc_en = 16'h0002;
    push("self_pc", S_IMA, 16'h0007);
    push("self_ar", S_DMA, 16'h0007);
    tick(); idle(); drain();
    peek(4'd2, "ar_bus", 16'h0007);

    // Store
    load(2, 16'h0010);
    load(4, 16'h5555);
    read_en = 4'd5; write_en = 16'h0800;
    #1;
    push("st_we",    S_DWE, 16'h0001);
    push("st_addr",  S_DMA, 16'h0010);
    push("st_wdata", S_DMW, 16'h5555);
    drain();
    tick(); idle();
    push("st_we_off", S_DWE, 16'h0000);
    push("st_ar",     S_DMA, 16'h0010);
    push("st_pc",     S_IMA, 16'h0007);
    drain();
    peek(4'd5, "st_ac", 16'h5555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
